tbd_obi_mgr_arb: RTL and testbench
==================================

Name: tbd_obi_mgr_arb

Overview:
Shares one OBI manager port between NUM_REQ requesters, for example the edge accelerator's read channel, its write channel and a future DMA.
- Arbitration is round-robin with a request lock: an ungranted request keeps the port until granted, as OBI requires.
- Grant order is tracked in an in-order ID FIFO, so each rvalid/rdata goes back to the requester that issued the transaction.
- Sits between the accelerator datapath and the crossbar manager port in the user domain.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (must be a multiple of 8).
- MAX_OUTST, 4, maximum in-flight transactions; this is also the ID FIFO depth (power of 2, at least 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request.
- we_i  in  NUM_REQ  per-requester write enable.
- addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k occupies slice k.
- be_i  in  NUM_REQ*DATA_WIDTH/8  packed byte enables.
- wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data.
- gnt_o  out  NUM_REQ  per-requester grant (one-hot or zero).
- rvalid_o  out  NUM_REQ  per-requester response valid (one-hot or zero).
- rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters.
- err_o  out  1  response error, broadcast; qualify with rvalid_o.
- mgr_req_o  out  1  manager request.
- mgr_we_o  out  1  manager write enable.
- mgr_addr_o  out  ADDR_WIDTH  manager address.
- mgr_be_o  out  DATA_WIDTH/8  manager byte enables.
- mgr_wdata_o  out  DATA_WIDTH  manager write data.
- mgr_gnt_i  in  1  manager grant.
- mgr_rvalid_i  in  1  manager response valid.
- mgr_rdata_i  in  DATA_WIDTH  manager read data.
- mgr_err_i  in  1  manager response error.
- outst_o  out  $clog2(MAX_OUTST+1)  current in-flight count.
- proto_err_o  out  1  sticky flag: rvalid arrived with no transaction outstanding.

Behaviour:
- Reset: all outputs 0, rr_ptr=0, lock cleared, FIFO empty, outst_o=0, proto_err_o=0. A reset mid-operation discards in-flight IDs; the manager side must be reset together with this block.
- Request path is combinational, zero added latency: mgr_* = fields of the selected requester sel; mgr_req_o = req_i[sel] && can_issue.
- can_issue = (outst < MAX_OUTST).
  - A same-cycle pop does not free a slot for a same-cycle issue.
- gnt_o[sel] = mgr_gnt_i && mgr_req_o; all other gnt_o bits are 0.
- Selection:
  - Locked (previous cycle had mgr_req_o=1 and mgr_gnt_i=0): sel = lock_idx, held regardless of other requests.
  - Otherwise: sel = first k with req_i[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - No requests: sel = rr_ptr and mgr_req_o=0.
- Lock register updates each cycle:
  - Set, with lock_idx=sel, when mgr_req_o && !mgr_gnt_i.
  - Cleared on handshake.
- A requester dropping req while locked violates OBI and is not supported.
- Handshake (mgr_req_o && mgr_gnt_i):
  - Push sel into the ID FIFO.
  - rr_ptr <= (sel+1) mod NUM_REQ.
- Response (mgr_rvalid_i):
  - FIFO non-empty: pop head h; rvalid_o[h]=1 combinationally in the same cycle; rdata_o=mgr_rdata_i; err_o=mgr_err_i.
  - FIFO empty: response dropped, rvalid_o stays 0, proto_err_o <= 1 (sticky until reset).
- Simultaneous push and pop: count unchanged; FIFO read/write pointers wrap modulo MAX_OUTST.
- OBI guarantees rvalid no earlier than the cycle after gnt, so a push never feeds a same-cycle pop of the same entry.
- Responses are strictly in order. The downstream crossbar is in-order per manager and this block relies on that.
- When outst=MAX_OUTST: mgr_req_o=0 and gnt_o=0; requests wait and the lock is not set, because mgr_req_o=0.

Test Plan:
1. Single requester: req_i=2'b01, read addr 0x1000, mgr_gnt_i same cycle, rvalid 1 cycle later with rdata=0xA5 → gnt_o=01, then rvalid_o=01, rdata_o=0xA5; outst_o goes 1 → 0.
2. Round-robin: req_i=2'b11 held, mgr_gnt_i=1 every cycle, responses 1 cycle later → grants alternate 01,10,01,10; each rvalid_o is routed to the matching issuer.
3. Lock: req_i[0] presented with mgr_gnt_i=0 for 3 cycles, req_i[1] raised in cycle 2, then gnt → mgr_addr_o stays requester 0's value throughout; requester 1 is granted on the next cycle.
4. Full: MAX_OUTST=4, grant 4 reads with no rvalid → outst_o=4 and mgr_req_o=0 despite req_i=11; one rvalid → outst_o=3, issue resumes the next cycle.
5. Stray response: mgr_rvalid_i pulse with nothing outstanding → rvalid_o=00, proto_err_o=1 and stays 1 until rst_ni low; err passthrough: mgr_err_i=1 with a response to requester 1 → err_o=1 with rvalid_o=10.
6. Reset mid-flight: 2 outstanding, rst_ni low 1 cycle → outst_o=0, all outputs 0, rr_ptr=0; the next request from requester 1 alone is granted normally.

Source files
------------

// File: rtl/tbd_obi_mgr_arb.sv
// -----------------------------------------------------------------------------
// tbd_obi_mgr_arb
//
// Shares one OBI manager port between NUM_REQ requesters. A round-robin
// arbiter picks a requester each cycle. Once a request has been presented
// downstream it is locked until it is granted, because OBI does not allow an
// ungranted request to be withdrawn or changed. Every handshake pushes the
// winning requester index into an in-order ID FIFO, and each manager response
// pops the head of that FIFO to route rvalid back to the issuer.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i/we_i             per-requester request and write enable
//   addr_i/be_i/wdata_i    packed per-requester fields (requester k = slice k)
//   gnt_o                  per-requester grant (one-hot or zero)
//   rvalid_o               per-requester response valid (one-hot or zero)
//   rdata_o/err_o          response data/error, broadcast, qualify with rvalid_o
//   mgr_*_o / mgr_*_i      the shared OBI manager port
//   outst_o                number of transactions currently in flight
//   proto_err_o            sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module tbd_obi_mgr_arb #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ-1:0]                we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    output logic [NUM_REQ-1:0]                rvalid_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              err_o,
    output logic                              mgr_req_o,
    output logic                              mgr_we_o,
    output logic [ADDR_WIDTH-1:0]             mgr_addr_o,
    output logic [DATA_WIDTH/8-1:0]           mgr_be_o,
    output logic [DATA_WIDTH-1:0]             mgr_wdata_o,
    input  logic                              mgr_gnt_i,
    input  logic                              mgr_rvalid_i,
    input  logic [DATA_WIDTH-1:0]             mgr_rdata_i,
    input  logic                              mgr_err_i,
    output logic [$clog2(MAX_OUTST+1)-1:0]    outst_o,
    output logic                              proto_err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // -------------------------------------------------------------------------
    // Unpack the per-requester fields into arrays for indexed selection
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [BE_W-1:0]       be_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign be_arr[gi]    = be_i[gi*BE_W +: BE_W];
            assign wdata_arr[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic             lock_q,     lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             proto_err_q, proto_err_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTST];

    // Wrapping increments; neither range is required to be a power of two
    // for the requester index, so the wrap is explicit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTST - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] p);
        if (p == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return p + IDX_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin scan starting at rr_ptr; falls back to rr_ptr when idle
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] rr_sel;
    logic [IDX_W-1:0] sel;
    logic             can_issue;
    logic             handshake;
    logic             pop;
    logic [IDX_W-1:0] head;

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        rr_sel = rr_ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                rr_sel = cand;
                found  = 1'b1;
            end
        end
    end

    // A locked request must stay on the bus unchanged until granted.
    assign sel       = lock_q ? lock_idx_q : rr_sel;
    // Uses the registered count: a same-cycle response does not open a slot.
    assign can_issue = (cnt_q < CNT_W'(MAX_OUTST));
    assign handshake = mgr_req_o && mgr_gnt_i;
    assign pop       = mgr_rvalid_i && (cnt_q != '0);
    assign head      = fifo_q[rd_ptr_q];

    // -------------------------------------------------------------------------
    // Request path (combinational, zero latency)
    // -------------------------------------------------------------------------
    assign mgr_req_o   = req_i[sel] && can_issue;
    assign mgr_we_o    = we_i[sel];
    assign mgr_addr_o  = addr_arr[sel];
    assign mgr_be_o    = be_arr[sel];
    assign mgr_wdata_o = wdata_arr[sel];

    always_comb begin
        gnt_o = '0;
        if (handshake) begin
            gnt_o[sel] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Response path: route to the FIFO head; stray responses are dropped
    // -------------------------------------------------------------------------
    always_comb begin
        rvalid_o = '0;
        if (pop) begin
            rvalid_o[head] = 1'b1;
        end
    end

    assign rdata_o     = pop ? mgr_rdata_i : '0;
    assign err_o       = pop && mgr_err_i;
    assign outst_o     = cnt_q;
    assign proto_err_o = proto_err_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        proto_err_d = proto_err_q;
        cnt_d       = cnt_q + CNT_W'(handshake) - CNT_W'(pop);

        if (mgr_req_o && !mgr_gnt_i) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end else if (handshake) begin
            lock_d = 1'b0;
        end

        if (handshake) begin
            rr_ptr_d = idx_inc(sel);
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (mgr_rvalid_i && (cnt_q == '0)) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // ID storage needs no reset: entries are only read while cnt_q says valid.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_tbd_obi_mgr_arb.sv
// -----------------------------------------------------------------------------
// Testbench for tbd_obi_mgr_arb (NUM_REQ=2, MAX_OUTST=4, 32-bit buses).
// Directed scenarios followed by OBI-legal random traffic, all checked against
// a transaction-level model (grant order queue, round-robin pointer, lock).
// -----------------------------------------------------------------------------
module tb_tbd_obi_mgr_arb;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Requester-side stimulus
    logic [N-1:0]  r_req, r_we;
    logic [AW-1:0] r_addr  [N];
    logic [BW-1:0] r_be    [N];
    logic [DW-1:0] r_wdata [N];

    logic [N-1:0]    req_i, we_i;
    logic [N*AW-1:0] addr_i;
    logic [N*BW-1:0] be_i;
    logic [N*DW-1:0] wdata_i;

    always_comb begin
        req_i   = r_req;
        we_i    = r_we;
        addr_i  = '0;
        be_i    = '0;
        wdata_i = '0;
        for (int k = 0; k < N; k++) begin
            addr_i[k*AW +: AW]  = r_addr[k];
            be_i[k*BW +: BW]    = r_be[k];
            wdata_i[k*DW +: DW] = r_wdata[k];
        end
    end

    // Manager-side stimulus
    logic          m_gnt, m_rvalid, m_err;
    logic [DW-1:0] m_rdata;

    // DUT outputs
    logic [N-1:0]  gnt_o, rvalid_o;
    logic [DW-1:0] rdata_o, mgr_wdata_o;
    logic          err_o, mgr_req_o, mgr_we_o, proto_err_o;
    logic [AW-1:0] mgr_addr_o;
    logic [BW-1:0] mgr_be_o;
    logic [CW-1:0] outst_o;

    tbd_obi_mgr_arb #(
        .NUM_REQ   (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_OUTST (MO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mgr_req_o   (mgr_req_o),
        .mgr_we_o    (mgr_we_o),
        .mgr_addr_o  (mgr_addr_o),
        .mgr_be_o    (mgr_be_o),
        .mgr_wdata_o (mgr_wdata_o),
        .mgr_gnt_i   (m_gnt),
        .mgr_rvalid_i(m_rvalid),
        .mgr_rdata_i (m_rdata),
        .mgr_err_i   (m_err),
        .outst_o     (outst_o),
        .proto_err_o (proto_err_o)
    );

    int n_tests;
    int n_fail;

    // -------------------------------------------------------------------------
    // Transaction-level reference model
    // -------------------------------------------------------------------------
    int     m_rr;          // next requester to favour
    bit     m_lock;        // an ungranted request is pending on the bus
    int     m_lock_idx;
    int     m_q[$];        // issuers of in-flight transactions, oldest first
    bit     m_perr;

    int        e_sel;
    logic      e_mreq;
    logic [N-1:0] e_gnt, e_rvalid;

    task automatic model_reset();
        m_rr     = 0;
        m_lock   = 1'b0;
        m_lock_idx = 0;
        m_q.delete();
        m_perr   = 1'b0;
    endtask

    task automatic model_eval();
        bit found;
        found = 1'b0;
        if (m_lock) begin
            e_sel = m_lock_idx;
        end else begin
            e_sel = m_rr;
            for (int i = 0; i < N; i++) begin
                if (!found && r_req[(m_rr + i) % N]) begin
                    e_sel = (m_rr + i) % N;
                    found = 1'b1;
                end
            end
        end
        e_mreq = r_req[e_sel] && (m_q.size() < MO);
        e_gnt  = '0;
        if (e_mreq && m_gnt) e_gnt[e_sel] = 1'b1;
        e_rvalid = '0;
        if (m_rvalid && m_q.size() > 0) e_rvalid[m_q[0]] = 1'b1;
    endtask

    task automatic model_commit();
        model_eval();
        if (m_rvalid) begin
            if (m_q.size() > 0) begin
                $display("[TB] t=%0t rsp  -> req%0d rdata=%h err=%0b", $time, m_q[0], m_rdata, m_err);
                void'(m_q.pop_front());
            end else begin
                $display("[TB] t=%0t rsp  stray, dropped", $time);
                m_perr = 1'b1;
            end
        end
        if (e_mreq && m_gnt) begin
            $display("[TB] t=%0t gnt  req%0d we=%0b addr=%h", $time, e_sel, r_we[e_sel], r_addr[e_sel]);
            m_q.push_back(e_sel);
            m_rr   = (e_sel + 1) % N;
            m_lock = 1'b0;
        end else if (e_mreq) begin
            m_lock     = 1'b1;
            m_lock_idx = e_sel;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_commit();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        r_req    = '0;
        r_we     = '0;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        m_rdata  = '0;
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        for (int k = 0; k < N; k++) begin
            r_addr[k] = '0; r_be[k] = '0; r_wdata[k] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end n_tests++;
        if (rvalid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", rvalid_o); end n_tests++;
        if (mgr_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mgr_req: got %b want 0", mgr_req_o); end n_tests++;
        if (outst_o !== 3'd0) begin n_fail++; $display("FAIL reset_outst: got %0d want 0", outst_o); end n_tests++;
        if (proto_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_proto: got %b want 0", proto_err_o); end n_tests++;
        if (err_o !== 1'b0 || rdata_o !== '0) begin n_fail++; $display("FAIL reset_rsp: got err=%b rdata=%h want 0", err_o, rdata_o); end n_tests++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        r_req = 2'b01; r_we = 2'b00; r_addr[0] = 32'h0000_1000; r_be[0] = 4'hF;
        m_gnt = 1'b1;
        #1;
        if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", gnt_o); end n_tests++;
        if (mgr_req_o !== 1'b1 || mgr_addr_o !== 32'h0000_1000 || mgr_we_o !== 1'b0) begin
            n_fail++; $display("FAIL single_req: got req=%b addr=%h we=%b want 1/00001000/0", mgr_req_o, mgr_addr_o, mgr_we_o);
        end n_tests++;
        tick();
        r_req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_00A5;
        #1;
        if (outst_o !== 3'd1) begin n_fail++; $display("FAIL single_outst1: got %0d want 1", outst_o); end n_tests++;
        if (rvalid_o !== 2'b01 || rdata_o !== 32'h0000_00A5) begin
            n_fail++; $display("FAIL single_rsp: got rvalid=%b rdata=%h want 01/000000a5", rvalid_o, rdata_o);
        end n_tests++;
        tick();
        m_rvalid = 1'b0;
        #1;
        if (outst_o !== 3'd0) begin n_fail++; $display("FAIL single_outst0: got %0d want 0", outst_o); end n_tests++;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] prev_gnt;
        prev_gnt = '0;
        r_req = 2'b11; r_addr[0] = 32'h0000_2000; r_addr[1] = 32'h0000_3000;
        m_gnt = 1'b1;
        for (int c = 0; c < 8; c++) begin
            m_rvalid = (c > 0);
            m_rdata  = $urandom;
            #1;
            model_eval();
            if (gnt_o !== e_gnt) begin n_fail++; $display("FAIL rr_gnt c=%0d: got %b want %b", c, gnt_o, e_gnt); end n_tests++;
            if (c > 0 && gnt_o !== ~prev_gnt) begin n_fail++; $display("FAIL rr_alternate c=%0d: got %b want %b", c, gnt_o, ~prev_gnt); end n_tests++;
            if (c > 0 && rvalid_o !== prev_gnt) begin n_fail++; $display("FAIL rr_route c=%0d: got %b want %b", c, rvalid_o, prev_gnt); end n_tests++;
            prev_gnt = e_gnt;
            tick();
        end
        r_req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1;
        #1;
        if (rvalid_o !== prev_gnt) begin n_fail++; $display("FAIL rr_route_last: got %b want %b", rvalid_o, prev_gnt); end n_tests++;
        tick();
        m_rvalid = 1'b0;
    endtask

    task automatic test_lock();
        r_req = 2'b01; r_addr[0] = 32'hAAAA_0000; r_addr[1] = 32'hBBBB_0000;
        m_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) r_req[1] = 1'b1;
            #1;
            if (mgr_addr_o !== 32'hAAAA_0000 || mgr_req_o !== 1'b1 || gnt_o !== 2'b00) begin
                n_fail++; $display("FAIL lock_hold c=%0d: got addr=%h req=%b gnt=%b want aaaa0000/1/00", c, mgr_addr_o, mgr_req_o, gnt_o);
            end n_tests++;
            tick();
        end
        m_gnt = 1'b1;
        #1;
        if (gnt_o !== 2'b01 || mgr_addr_o !== 32'hAAAA_0000) begin
            n_fail++; $display("FAIL lock_gnt0: got gnt=%b addr=%h want 01/aaaa0000", gnt_o, mgr_addr_o);
        end n_tests++;
        tick();
        r_req[0] = 1'b0;
        #1;
        if (gnt_o !== 2'b10 || mgr_addr_o !== 32'hBBBB_0000) begin
            n_fail++; $display("FAIL lock_gnt1: got gnt=%b addr=%h want 10/bbbb0000", gnt_o, mgr_addr_o);
        end n_tests++;
        tick();
        r_req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1;
        #1;
        if (rvalid_o !== 2'b01) begin n_fail++; $display("FAIL lock_rsp0: got %b want 01", rvalid_o); end n_tests++;
        tick();
        #1;
        if (rvalid_o !== 2'b10) begin n_fail++; $display("FAIL lock_rsp1: got %b want 10", rvalid_o); end n_tests++;
        tick();
        m_rvalid = 1'b0;
    endtask

    task automatic test_full();
        r_req = 2'b11; m_gnt = 1'b1;
        for (int c = 0; c < MO; c++) begin
            #1;
            model_eval();
            if (gnt_o !== e_gnt || gnt_o === 2'b00) begin n_fail++; $display("FAIL full_fill c=%0d: got %b want %b", c, gnt_o, e_gnt); end n_tests++;
            tick();
        end
        m_gnt = 1'b0;
        #1;
        if (outst_o !== 3'd4 || mgr_req_o !== 1'b0) begin
            n_fail++; $display("FAIL full_block: got outst=%0d req=%b want 4/0", outst_o, mgr_req_o);
        end n_tests++;
        tick();
        m_gnt = 1'b1;
        #1;
        if (mgr_req_o !== 1'b0 || gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL full_nognt: got req=%b gnt=%b want 0/00", mgr_req_o, gnt_o);
        end n_tests++;
        tick();
        m_rvalid = 1'b1;
        #1;
        model_eval();
        if (outst_o !== 3'd4 || mgr_req_o !== 1'b0 || rvalid_o !== e_rvalid) begin
            n_fail++; $display("FAIL full_pop: got outst=%0d req=%b rvalid=%b want 4/0/%b", outst_o, mgr_req_o, rvalid_o, e_rvalid);
        end n_tests++;
        tick();
        m_rvalid = 1'b0;
        #1;
        model_eval();
        if (outst_o !== 3'd3 || mgr_req_o !== 1'b1 || gnt_o !== e_gnt) begin
            n_fail++; $display("FAIL full_resume: got outst=%0d req=%b gnt=%b want 3/1/%b", outst_o, mgr_req_o, gnt_o, e_gnt);
        end n_tests++;
        tick();
        r_req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1;
        for (int c = 0; c < MO; c++) begin
            #1;
            model_eval();
            if (rvalid_o !== e_rvalid) begin n_fail++; $display("FAIL full_drain c=%0d: got %b want %b", c, rvalid_o, e_rvalid); end n_tests++;
            tick();
        end
        m_rvalid = 1'b0;
        #1;
        if (outst_o !== 3'd0) begin n_fail++; $display("FAIL full_empty: got %0d want 0", outst_o); end n_tests++;
    endtask

    task automatic test_stray_err();
        idle_inputs();
        m_rvalid = 1'b1;
        #1;
        if (rvalid_o !== 2'b00 || proto_err_o !== 1'b0) begin
            n_fail++; $display("FAIL stray_drop: got rvalid=%b proto=%b want 00/0", rvalid_o, proto_err_o);
        end n_tests++;
        tick();
        m_rvalid = 1'b0;
        #1;
        if (proto_err_o !== 1'b1) begin n_fail++; $display("FAIL stray_flag: got %b want 1", proto_err_o); end n_tests++;
        r_req = 2'b10; r_addr[1] = 32'h0000_00C0; m_gnt = 1'b1;
        #1;
        if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL err_issue: got %b want 10", gnt_o); end n_tests++;
        tick();
        r_req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b1; m_err = 1'b1; m_rdata = 32'h0000_005A;
        #1;
        if (rvalid_o !== 2'b10 || err_o !== 1'b1 || rdata_o !== 32'h0000_005A) begin
            n_fail++; $display("FAIL err_pass: got rvalid=%b err=%b rdata=%h want 10/1/0000005a", rvalid_o, err_o, rdata_o);
        end n_tests++;
        tick();
        m_rvalid = 1'b0; m_err = 1'b0;
        repeat (3) tick();
        #1;
        if (proto_err_o !== 1'b1) begin n_fail++; $display("FAIL stray_sticky: got %b want 1", proto_err_o); end n_tests++;
    endtask

    task automatic test_reset_midflight();
        r_req = 2'b01; r_addr[0] = 32'h0000_4000; m_gnt = 1'b1;
        tick();
        tick();
        idle_inputs();
        #1;
        if (outst_o !== 3'd2) begin n_fail++; $display("FAIL mid_outst: got %0d want 2", outst_o); end n_tests++;
        rst_n = 1'b0;
        #1;
        if (outst_o !== 3'd0 || proto_err_o !== 1'b0 || gnt_o !== 2'b00 || rvalid_o !== 2'b00 || mgr_req_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got outst=%0d proto=%b gnt=%b rvalid=%b req=%b want all 0",
                               outst_o, proto_err_o, gnt_o, rvalid_o, mgr_req_o);
        end n_tests++;
        model_reset();
        @(negedge clk);
        r_addr[0] = 32'h0000_D000; r_addr[1] = 32'h0000_E000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // With no requests the selection rests on rr_ptr, which must be 0.
        if (mgr_addr_o !== 32'h0000_D000) begin n_fail++; $display("FAIL mid_rrptr: got addr=%h want 0000d000", mgr_addr_o); end n_tests++;
        r_req = 2'b10; m_gnt = 1'b1;
        #1;
        if (gnt_o !== 2'b10 || mgr_addr_o !== 32'h0000_E000) begin
            n_fail++; $display("FAIL mid_gnt: got gnt=%b addr=%h want 10/0000e000", gnt_o, mgr_addr_o);
        end n_tests++;
        tick();
        idle_inputs();
        m_rvalid = 1'b1;
        #1;
        if (rvalid_o !== 2'b10 || outst_o !== 3'd1) begin
            n_fail++; $display("FAIL mid_rsp: got rvalid=%b outst=%0d want 10/1", rvalid_o, outst_o);
        end n_tests++;
        tick();
        m_rvalid = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!r_req[k] && $urandom_range(1, 0) == 1) begin
                    r_req[k]   = 1'b1;
                    r_we[k]    = 1'($urandom);
                    r_addr[k]  = $urandom;
                    r_be[k]    = BW'($urandom);
                    r_wdata[k] = $urandom;
                end
            end
            m_gnt = ($urandom_range(9, 0) < 7);
            if (m_q.size() > 0) m_rvalid = ($urandom_range(9, 0) < 6);
            else                m_rvalid = ($urandom_range(99, 0) < 3);
            m_rdata = $urandom;
            m_err   = 1'($urandom);
            #1;
            model_eval();
            if (gnt_o !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d: got %b want %b", cyc, gnt_o, e_gnt); end n_tests++;
            if (rvalid_o !== e_rvalid) begin n_fail++; $display("FAIL rnd_rvalid cyc=%0d: got %b want %b", cyc, rvalid_o, e_rvalid); end n_tests++;
            if (mgr_req_o !== e_mreq) begin n_fail++; $display("FAIL rnd_req cyc=%0d: got %b want %b", cyc, mgr_req_o, e_mreq); end n_tests++;
            if (mgr_addr_o !== r_addr[e_sel] || mgr_we_o !== r_we[e_sel] || mgr_be_o !== r_be[e_sel] || mgr_wdata_o !== r_wdata[e_sel]) begin
                n_fail++; $display("FAIL rnd_fields cyc=%0d: got addr=%h we=%b be=%h wdata=%h want %h/%b/%h/%h", cyc,
                                   mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o, r_addr[e_sel], r_we[e_sel], r_be[e_sel], r_wdata[e_sel]);
            end n_tests++;
            if (outst_o !== CW'(m_q.size())) begin n_fail++; $display("FAIL rnd_outst cyc=%0d: got %0d want %0d", cyc, outst_o, m_q.size()); end n_tests++;
            if (proto_err_o !== m_perr) begin n_fail++; $display("FAIL rnd_proto cyc=%0d: got %b want %b", cyc, proto_err_o, m_perr); end n_tests++;
            if (e_rvalid != '0) begin
                if (rdata_o !== m_rdata || err_o !== m_err) begin
                    n_fail++; $display("FAIL rnd_rsp cyc=%0d: got rdata=%h err=%b want %h/%b", cyc, rdata_o, err_o, m_rdata, m_err);
                end n_tests++;
            end
            g = e_gnt;
            tick();
            for (int k = 0; k < N; k++) begin
                if (g[k]) r_req[k] = 1'b0;
            end
        end
        idle_inputs();
        for (int c = 0; c < 2 * MO && m_q.size() > 0; c++) begin
            m_rvalid = 1'b1;
            #1;
            model_eval();
            if (rvalid_o !== e_rvalid) begin n_fail++; $display("FAIL rnd_drain c=%0d: got %b want %b", c, rvalid_o, e_rvalid); end n_tests++;
            tick();
        end
        m_rvalid = 1'b0;
        #1;
        if (outst_o !== 3'd0) begin n_fail++; $display("FAIL rnd_empty: got %0d want 0", outst_o); end n_tests++;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_full();
        test_stray_err();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
